// File: rtl/jk_bank_driver_if.sv
// Handshake and excitation bundle between control logic, jk_bank_driver
// and the JK flip-flop bank it drives.
// master: control/bank side. slave: the driver.
interface jk_bank_driver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_fb;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_mask;
  logic [7:0]       err_cnt;

  modport master (
    output tgt_data, tgt_valid, q_fb,
    input  tgt_ready, j, k, done, err, err_mask, err_cnt
  );

  modport slave (
    input  tgt_data, tgt_valid, q_fb,
    output tgt_ready, j, k, done, err, err_mask, err_cnt
  );
endinterface

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: accepts a target word, drives one edge of J/K excitation
// into a JK flip-flop bank, waits SETTLE cycles, then checks the bank's Q.
// Build option: define JK_TOGGLE_EN to drive differing bits as toggles
// (j=k=1); otherwise differing bits use set/reset encoding (j=t, k=~t).
module jk_bank_driver #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input logic             clk,
  input logic             reset,
  jk_bank_driver_if.slave bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_p0;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             check;

  logic [WIDTH-1:0] target_p0;
  logic [WIDTH-1:0] j_p0;
  logic [WIDTH-1:0] k_p0;
  logic             done_p1;
  logic             err_p1;
  logic [WIDTH-1:0] err_mask_p1;
  logic [7:0]       err_cnt_p1;
  logic [WIDTH-1:0] diff;

  // J excitation for bits whose current Q differs from the target
  function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EN
    return q ^ t;
`else
    return (q ^ t) & t;
`endif
  endfunction

  // K excitation for bits whose current Q differs from the target
  function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EN
    return q ^ t;
`else
    return (q ^ t) & ~t;
`endif
  endfunction

  // Failure counter sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign diff          = bus.q_fb ^ target_p0;
  assign bus.tgt_ready = (state_p0 == S_IDLE);
  assign bus.j         = j_p0;
  assign bus.k         = k_p0;
  assign bus.done      = done_p1;
  assign bus.err       = err_p1;
  assign bus.err_mask  = err_mask_p1;
  assign bus.err_cnt   = err_cnt_p1;

  // State and settle counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= S_IDLE;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  // Next-state logic; accept and check are the two edge events
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    accept    = 1'b0;
    check     = 1'b0;
    case (state_p0)
      S_IDLE: begin
        if (bus.tgt_valid) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_nxt = S_WAIT;
        cnt_nxt   = CNT_W'(SETTLE);
      end
      S_WAIT: begin
        if (cnt_p0 <= CNT_W'(1)) begin
          check     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_p0 - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: target capture and one-edge excitation; stage p1: check result
  always_ff @(posedge clk) begin
    if (reset) begin
      target_p0   <= '0;
      j_p0        <= '0;
      k_p0        <= '0;
      done_p1     <= 1'b0;
      err_p1      <= 1'b0;
      err_mask_p1 <= '0;
      err_cnt_p1  <= '0;
    end else begin
      j_p0    <= '0;
      k_p0    <= '0;
      done_p1 <= 1'b0;
      if (accept) begin
        target_p0 <= bus.tgt_data;
        j_p0      <= exc_j(bus.q_fb, bus.tgt_data);
        k_p0      <= exc_k(bus.q_fb, bus.tgt_data);
      end
      if (check) begin
        done_p1     <= 1'b1;
        err_p1      <= |diff;
        err_mask_p1 <= diff;
        if (|diff) err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (SETTLE=1 and SETTLE=3), each
// driving a behavioural JK flip-flop bank model. Expectations follow the
// JK_TOGGLE_EN build selection.
module tb_jk_bank_driver;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  jk_bank_driver_if #(.WIDTH(W)) a_if ();
  jk_bank_driver_if #(.WIDTH(W)) b_if ();

  jk_bank_driver #(.WIDTH(W), .SETTLE(1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  jk_bank_driver #(.WIDTH(W), .SETTLE(3)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

  // JK bank models: q+ = j&~q | ~k&q, with optional stuck-at-0 bits on bank A
  logic [W-1:0] bank_a, bank_b, ld_val, stuck;
  logic         ld = 1'b0;
  always @(posedge clk) begin
    if (reset)   bank_a <= '0;
    else if (ld) bank_a <= ld_val;
    else         bank_a <= ((a_if.j & ~bank_a) | (~a_if.k & bank_a)) & ~stuck;
  end
  always @(posedge clk) begin
    if (reset) bank_b <= '0;
    else       bank_b <= (b_if.j & ~bank_b) | (~b_if.k & bank_b);
  end
  assign a_if.q_fb = bank_a;
  assign b_if.q_fb = bank_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] q0;
    logic [W-1:0] tgt;
    logic [W-1:0] stk;
    logic [W-1:0] j_tog, k_tog;
    logic [W-1:0] j_sr, k_sr;
    logic         e;
    logic [W-1:0] mask;
    logic [W-1:0] qf;
  } vec_t;

  vec_t vecs[5];

  // One transaction on DUT A (SETTLE=1): accept at E0, done at E0+2
  task automatic run_vec(input vec_t v, input bit quiet);
    logic [W-1:0] ej, ek;
`ifdef JK_TOGGLE_EN
    ej = v.j_tog; ek = v.k_tog;
`else
    ej = v.j_sr;  ek = v.k_sr;
`endif
    @(negedge clk);
    ld = 1'b1; ld_val = v.q0; stuck = v.stk;
    @(negedge clk);
    ld = 1'b0; a_if.tgt_data = v.tgt; a_if.tgt_valid = 1'b1;
    @(posedge clk); #1;
    if (!quiet) begin
      chk("ready_drive", 32'(a_if.tgt_ready), 32'd0);
      chk("j_drive", 32'(a_if.j), 32'(ej));
      chk("k_drive", 32'(a_if.k), 32'(ek));
    end
    @(negedge clk);
    a_if.tgt_valid = 1'b0;
    @(posedge clk); #1;
    if (!quiet) begin
      chk("done_wait", 32'(a_if.done), 32'd0);
      chk("jk_wait", 32'({a_if.j, a_if.k}), 32'd0);
      chk("ready_wait", 32'(a_if.tgt_ready), 32'd0);
    end
    @(posedge clk); #1;
    if (!quiet) begin
      chk("done", 32'(a_if.done), 32'd1);
      chk("err", 32'(a_if.err), 32'(v.e));
      chk("err_mask", 32'(a_if.err_mask), 32'(v.mask));
      chk("bank_q", 32'(bank_a), 32'(v.qf));
      chk("ready_done", 32'(a_if.tgt_ready), 32'd1);
    end
    @(posedge clk); #1;
    if (!quiet) begin
      chk("done_pulse", 32'(a_if.done), 32'd0);
      chk("err_hold", 32'(a_if.err), 32'(v.e));
      chk("mask_hold", 32'(a_if.err_mask), 32'(v.mask));
    end
  endtask

  initial begin
    //          q0       tgt      stuck    j_tog    k_tog    j_sr     k_sr     e     mask     qf
    vecs[0] = '{4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 1'b0, 4'b0000, 4'b1010};
    vecs[1] = '{4'b1111, 4'b0110, 4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b1001, 1'b0, 4'b0000, 4'b0110};
    vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0101};
    vecs[3] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0000};
    vecs[4] = '{4'b1100, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 4'b0011, 4'b1100, 1'b0, 4'b0000, 4'b0011};

    stuck = '0; ld_val = '0;
    a_if.tgt_data = 4'b1111; a_if.tgt_valid = 1'b1;
    b_if.tgt_data = 4'b0000; b_if.tgt_valid = 1'b1;

    // Reset with tgt_valid high: nothing may be accepted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(a_if.tgt_ready), 32'd1);
    chk("rst_jk", 32'({a_if.j, a_if.k}), 32'd0);
    chk("rst_outs", 32'({a_if.done, a_if.err, a_if.err_mask, a_if.err_cnt}), 32'd0);
    chk("rst_ready_b", 32'(b_if.tgt_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0; a_if.tgt_valid = 1'b0; b_if.tgt_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(a_if.tgt_ready), 32'd1);

    // Directed excitation vectors
    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);
    chk("err_cnt_one", 32'(a_if.err_cnt), 32'd1);

    // Saturation: 253 more failures reach 254, one more 255, then stays
    for (int i = 0; i < 253; i++) run_vec(vecs[3], 1'b1);
    chk("err_cnt_254", 32'(a_if.err_cnt), 32'd254);
    run_vec(vecs[3], 1'b1);
    chk("err_cnt_255", 32'(a_if.err_cnt), 32'd255);
    for (int i = 0; i < 46; i++) run_vec(vecs[3], 1'b1);
    chk("err_cnt_sat", 32'(a_if.err_cnt), 32'd255);
    chk("err_before_rst", 32'(a_if.err), 32'd1);

    // Reset during WAIT: no done, everything back to reset values
    @(negedge clk);
    ld = 1'b1; ld_val = 4'b0000; stuck = 4'b0100;
    @(negedge clk);
    ld = 1'b0; a_if.tgt_data = 4'b0100; a_if.tgt_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_if.tgt_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("wrst_done", 32'(a_if.done), 32'd0);
    chk("wrst_ready", 32'(a_if.tgt_ready), 32'd1);
    chk("wrst_err", 32'({a_if.err, a_if.err_mask}), 32'd0);
    chk("wrst_cnt", 32'(a_if.err_cnt), 32'd0);
    chk("wrst_jk", 32'({a_if.j, a_if.k}), 32'd0);
    @(negedge clk);
    reset = 1'b0; stuck = '0;
    @(posedge clk); #1;
    chk("wrst_no_done", 32'(a_if.done), 32'd0);

    // Throughput on DUT B (SETTLE=3): valid held high, accept every 5 cycles
    @(negedge clk);
    b_if.tgt_data = 4'b1010; b_if.tgt_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      chk($sformatf("b_ready_%0d", n), 32'(b_if.tgt_ready), 32'((n % 5) == 4));
      chk($sformatf("b_done_%0d", n), 32'(b_if.done), 32'((n % 5) == 4));
      if (n == 0) chk("b_j_first", 32'(b_if.j), 32'(4'b1010));
      if ((n % 5) != 0) chk($sformatf("b_jk_%0d", n), 32'({b_if.j, b_if.k}), 32'd0);
    end
    chk("b_bank", 32'(bank_b), 32'(4'b1010));
    chk("b_err", 32'(b_if.err), 32'd0);
    @(negedge clk);
    b_if.tgt_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Sequential excitation driver for a bank of JK flip-flops on the same clock. It accepts a target WIDTH-bit word over a valid/ready handshake and derives per-bit J/K excitation from the bank's current Q. It drives that excitation for exactly one clock edge, then checks the bank's Q against the target and reports pass/fail. It sits between test/control logic and any JK flip-flop bank, and implements the excitation-table direction of the JK characteristic behaviour.

## Interface
- WIDTH, 4: number of JK flip-flops driven (1..32).
- SETTLE, 1: cycles with J=K=0 between drive and check (1..15).

- clk  input  1  rising-edge clock, shared with the flip-flop bank.
- reset  input  1  synchronous, active-high reset.
- tgt_data  input  WIDTH  requested next Q of the bank.
- tgt_valid  input  1  tgt_data valid.
- tgt_ready  output  1  block can accept a target (high only in IDLE).
- j  output  WIDTH  J excitation, registered.
- k  output  WIDTH  K excitation, registered.
- q_fb  input  WIDTH  Q of the flip-flop bank (same clock domain, no synchronizer).
- done  output  1  one-cycle pulse: check complete.
- err  output  1  valid with done: Q mismatched target.
- err_mask  output  WIDTH  q_fb ^ target captured at check; held until next check.
- err_cnt  output  8  saturating count of failed checks.

## Operation
- States: IDLE, DRIVE, WAIT, CHECK-on-exit (the check happens on the edge leaving WAIT).
- IDLE: tgt_ready=1, j=k=0. When tgt_valid&tgt_ready at an edge:
  - latch tgt_data into target;
  - compute j/k from q_fb sampled at that same edge;
  - go to DRIVE.
- DRIVE (exactly 1 cycle): j/k hold the computed excitation, tgt_ready=0. At the next edge, j/k clear to 0 and the state goes to WAIT with the settle counter loaded to SETTLE.
- WAIT (SETTLE cycles): j=k=0. At the edge ending the last WAIT cycle:
  - sample q_fb and register done=1, err=|(q_fb^target), err_mask=q_fb^target;
  - increment err_cnt if err, saturating at 255;
  - go to IDLE.
- Excitation per bit, with current q = q_fb at accept and target bit t:
  - q==t: j=0, k=0 (hold).
  - q!=t: encoding selected by the Configuration macro.
- A target equal to the current Q still runs the full sequence: j=k=0 in DRIVE, and done with err=0.
- done deasserts after one cycle. err and err_mask hold until the next check or reset.
- tgt_data is ignored outside IDLE. Back-pressure is via tgt_ready only.

## Timing
- Reset (synchronous, any state, including mid-DRIVE/WAIT): after the reset edge, state=IDLE, j=0, k=0, done=0, err=0, err_mask=0, err_cnt=0, tgt_ready=1. Any in-flight target is discarded and no done is issued.
- Reset has priority over the handshake: tgt_valid during reset is not accepted.
- For a handshake at edge E0:
  - j/k are valid in cycle E0..E0+1;
  - the bank updates at E0+1;
  - done/err/err_mask are registered at E0+1+SETTLE;
  - tgt_ready returns high in the same cycle as done.
- Back-to-back: a new target can be accepted at the edge ending the done cycle. Throughput is one target per SETTLE+2 cycles.
- j/k are never nonzero in any state but DRIVE.

## Configuration
- JK_TOGGLE_EN defined: each differing bit drives j=1, k=1 (toggle).
- JK_TOGGLE_EN undefined: each differing bit drives set/reset encoding, j=t, k=~t (0→1: j=1,k=0; 1→0: j=0,k=1).
- Hold bits are j=k=0 in both builds.
- All check and handshake timing is identical in both builds.

## Test plan
- Reset, then WIDTH=4, q_fb=0000, target 1010 accepted at E0 → in DRIVE j=1010 with k=1010 (toggle build) or k=0000 (undefined build). The model bank reaches 1010, and done=1, err=0 at E0+2 (SETTLE=1).
- q_fb=1111, target 0110 → toggle build: j=k=1001; undefined build: j=0000, k=1001. Q becomes 0110, err=0.
- Target 0101 equal to q_fb → j=k=0000 in DRIVE, done with err=0, err_mask=0000.
- Model bank forces bit 2 stuck at 0, target 0100 from 0000 → err=1, err_mask=0100, err_cnt increments. Repeating 300 times → err_cnt saturates at 255.
- Assert reset during WAIT → no done pulse, all outputs take reset values next cycle, tgt_ready=1.
- tgt_valid held high continuously with SETTLE=3 → accepts exactly every 5 cycles, and tgt_ready is low in DRIVE/WAIT.
